gray_decoder_monitor: RTL and testbench

GRAY_DECODER_MONITOR -- requirements
Module: gray_decoder_monitor

---
 rtl/gray_decoder_monitor.sv | 166 ++++++++++++++++
 tb/tb_gray_decoder_monitor.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_decoder_monitor.sv
// gray_decoder_monitor
//   Accepts Gray-coded samples from an upstream encoder, decodes them to
//   binary and classifies each accepted sample against the previous one as
//   an up step, a down step, a repeat, or an invalid jump (more than one bit
//   changed). Too many invalid jumps in a row drops the monitor out of sync.
//
//   Handshake: gray_in is consumed on a rising edge when gray_valid is high
//   (and the block is armed after reset). There is no back-pressure. Results
//   appear one cycle later, with bin_valid pulsing for exactly one cycle.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   gray_in      Gray-coded sample (WIDTH bits)
//   gray_valid   gray_in qualifier
//   clear_err    synchronous clear of err_count (wins over a same-cycle error)
//   bin_out      registered binary decode of the last accepted sample
//   bin_valid    one-cycle pulse: bin_out updated
//   step_up      one-cycle pulse: sample is previous +1 (mod 2^WIDTH)
//   step_dn      one-cycle pulse: sample is previous -1 (mod 2^WIDTH)
//   step_err     one-cycle pulse: sample differs in more than one bit
//   in_sync      FSM state, high in SYNC
//   err_count    saturating count of step_err events
module gray_decoder_monitor #(
  parameter int WIDTH     = 4,
  parameter int ERR_LIMIT = 3,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             gray_valid,
  input  logic             clear_err,
  output logic [WIDTH-1:0] bin_out,
  output logic             bin_valid,
  output logic             step_up,
  output logic             step_dn,
  output logic             step_err,
  output logic             in_sync,
  output logic [CNT_W-1:0] err_count
);

  localparam int CONS_W = (ERR_LIMIT < 2) ? 1 : $clog2(ERR_LIMIT + 1);

  localparam logic [0:0] ST_UNSYNC = 1'b0;
  localparam logic [0:0] ST_SYNC   = 1'b1;

  localparam logic [WIDTH-1:0]  BIN_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CONS_W-1:0] CONS_ONE = {{(CONS_W-1){1'b0}}, 1'b1};
  localparam logic [CONS_W-1:0] CONS_LIM = CONS_W'(ERR_LIMIT);

  logic [0:0]        state_q, state_d;
  logic              arm_q;
  logic [WIDTH-1:0]  gray_q, gray_d;
  logic [WIDTH-1:0]  bin_q, bin_d;
  logic              valid_q, valid_d;
  logic              up_q, up_d;
  logic              dn_q, dn_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CONS_W-1:0] consec_q, consec_d;

  logic [WIDTH-1:0]  bin_dec;
  logic [WIDTH-1:0]  diff;
  logic              one_bit;
  logic              accept;

  // Binary bit i is the XOR of all Gray bits at or above i.
  always_comb begin
    bin_dec = '0;
    for (int i = 0; i < WIDTH; i++) begin
      bin_dec[i] = ^(gray_in >> i);
    end
  end

  assign diff    = gray_in ^ gray_q;
  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  assign one_bit = (diff != '0) && ((diff & (diff - BIN_ONE)) == '0);

  // arm_q stays low through the first edge after reset release so a sample
  // presented while reset is lifting is never taken.
  assign accept  = gray_valid && arm_q;

  always_comb begin
    state_d  = state_q;
    gray_d   = gray_q;
    bin_d    = bin_q;
    valid_d  = 1'b0;
    up_d     = 1'b0;
    dn_d     = 1'b0;
    err_d    = 1'b0;
    cnt_d    = cnt_q;
    consec_d = consec_q;

    if (accept) begin
      valid_d = 1'b1;
      gray_d  = gray_in;
      bin_d   = bin_dec;
      if (state_q == ST_UNSYNC) begin
        // First sample becomes the reference; nothing to compare against.
        state_d  = ST_SYNC;
        consec_d = '0;
      end else if (diff == '0) begin
        consec_d = '0;
      end else if (one_bit) begin
        consec_d = '0;
        if (bin_dec == bin_q + BIN_ONE) begin
          up_d = 1'b1;
        end else begin
          dn_d = 1'b1;
        end
      end else begin
        err_d = 1'b1;
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_ONE;
        end
        if (consec_q == CONS_LIM - CONS_ONE) begin
          state_d  = ST_UNSYNC;
          consec_d = '0;
        end else begin
          consec_d = consec_q + CONS_ONE;
        end
      end
    end

    if (clear_err) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_UNSYNC;
      arm_q    <= 1'b0;
      gray_q   <= '0;
      bin_q    <= '0;
      valid_q  <= 1'b0;
      up_q     <= 1'b0;
      dn_q     <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      consec_q <= '0;
    end else begin
      state_q  <= state_d;
      arm_q    <= 1'b1;
      gray_q   <= gray_d;
      bin_q    <= bin_d;
      valid_q  <= valid_d;
      up_q     <= up_d;
      dn_q     <= dn_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      consec_q <= consec_d;
    end
  end

  assign bin_out   = bin_q;
  assign bin_valid = valid_q;
  assign step_up   = up_q;
  assign step_dn   = dn_q;
  assign step_err  = err_q;
  assign in_sync   = (state_q == ST_SYNC);
  assign err_count = cnt_q;

endmodule

// File: tb/tb_gray_decoder_monitor.sv
// Bench for gray_decoder_monitor (WIDTH=4, ERR_LIMIT=3, CNT_W=8).
// Expected output words are {bin, valid, up, dn, err, sync, cnt}.
module tb_gray_decoder_monitor;

  localparam int WIDTH     = 4;
  localparam int ERR_LIMIT = 3;
  localparam int CNT_W     = 8;
  localparam int EW        = WIDTH + 5 + CNT_W;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] gray_in;
  logic             gray_valid;
  logic             clear_err;
  logic [WIDTH-1:0] bin_out;
  logic             bin_valid;
  logic             step_up;
  logic             step_dn;
  logic             step_err;
  logic             in_sync;
  logic [CNT_W-1:0] err_count;

  int checks = 0;
  int errors = 0;

  logic [EW-1:0] exp_q[$];

  // Reference model state
  logic             m_sync;
  logic [WIDTH-1:0] m_gray;
  logic [WIDTH-1:0] m_bin;
  int               m_consec;
  logic [CNT_W-1:0] m_cnt;

  gray_decoder_monitor #(
    .WIDTH    (WIDTH),
    .ERR_LIMIT(ERR_LIMIT),
    .CNT_W    (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .gray_in   (gray_in),
    .gray_valid(gray_valid),
    .clear_err (clear_err),
    .bin_out   (bin_out),
    .bin_valid (bin_valid),
    .step_up   (step_up),
    .step_dn   (step_dn),
    .step_err  (step_err),
    .in_sync   (in_sync),
    .err_count (err_count)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  function automatic logic [EW-1:0] pack(input logic [WIDTH-1:0] b, input logic v,
                                         input logic u, input logic d, input logic e,
                                         input logic s, input logic [CNT_W-1:0] n);
    return {b, v, u, d, e, s, n};
  endfunction

  function automatic logic [WIDTH-1:0] g2b(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic [EW-1:0] actual();
    return pack(bin_out, bin_valid, step_up, step_dn, step_err, in_sync, err_count);
  endfunction

  task automatic compare(input string name, input logic [EW-1:0] req);
    logic [EW-1:0] act;
    act = actual();
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual bin=%h v=%b up=%b dn=%b err=%b sync=%b cnt=%0d, required bin=%h v=%b up=%b dn=%b err=%b sync=%b cnt=%0d",
               name, act[EW-1 -: WIDTH], act[CNT_W+4], act[CNT_W+3], act[CNT_W+2],
               act[CNT_W+1], act[CNT_W], act[CNT_W-1:0],
               req[EW-1 -: WIDTH], req[CNT_W+4], req[CNT_W+3], req[CNT_W+2],
               req[CNT_W+1], req[CNT_W], req[CNT_W-1:0]);
    end
  endtask

  // Pop the oldest expectation and compare it with what the DUT shows now.
  task automatic score(input string name);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty when output was sampled", name);
    end else begin
      compare(name, exp_q.pop_front());
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive_cycle(input string name, input logic v, input logic [WIDTH-1:0] g,
                             input logic c, input logic [EW-1:0] e);
    @(negedge clk);
    gray_valid = v;
    gray_in    = g;
    clear_err  = c;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    score(name);
  endtask

  task automatic model_reset();
    m_sync   = 1'b0;
    m_gray   = '0;
    m_bin    = '0;
    m_consec = 0;
    m_cnt    = '0;
  endtask

  task automatic model_cycle(input string name, input logic v, input logic [WIDTH-1:0] g,
                             input logic c);
    logic [WIDTH-1:0] b;
    logic up, dn, er;
    int hd;
    up = 1'b0; dn = 1'b0; er = 1'b0;
    b  = g2b(g);
    hd = $countones(g ^ m_gray);
    if (v) begin
      if (!m_sync) begin
        m_sync   = 1'b1;
        m_consec = 0;
      end else if (hd == 1) begin
        if ((int'(m_bin) + 1) % (1 << WIDTH) == int'(b)) up = 1'b1;
        else dn = 1'b1;
        m_consec = 0;
      end else if (hd > 1) begin
        er = 1'b1;
        if (m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
        m_consec++;
        if (m_consec == ERR_LIMIT) begin
          m_sync   = 1'b0;
          m_consec = 0;
        end
      end else begin
        m_consec = 0;
      end
      m_gray = g;
      m_bin  = b;
    end
    if (c) m_cnt = '0;
    drive_cycle(name, v, g, c, pack(m_bin, v, up, dn, er, m_sync, m_cnt));
  endtask

  // Reset with all outputs checked at zero, release on a falling edge, then
  // one idle cycle so the block is armed.
  task automatic do_reset(input string name);
    gray_valid = 1'b0;
    gray_in    = '0;
    clear_err  = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    compare({name, "_zero"}, '0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive_cycle({name, "_arm"}, 1'b0, '0, 1'b0, '0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [WIDTH-1:0] g;
    logic             v;
    logic             c;
    logic [EW-1:0]    exp;
  } vec_t;

  localparam int NV = 25;
  vec_t tbl[NV];

  initial begin
    rst_n      = 1'b0;
    gray_valid = 1'b0;
    gray_in    = '0;
    clear_err  = 1'b0;

    //             gray     v     c     bin   v  up dn er sy cnt
    tbl[0]  = '{4'b0000, 1'b1, 1'b0, pack(4'd0,  1, 0, 0, 0, 1, 8'd0)};
    tbl[1]  = '{4'b0001, 1'b1, 1'b0, pack(4'd1,  1, 1, 0, 0, 1, 8'd0)};
    tbl[2]  = '{4'b0011, 1'b1, 1'b0, pack(4'd2,  1, 1, 0, 0, 1, 8'd0)};
    tbl[3]  = '{4'b0010, 1'b1, 1'b0, pack(4'd3,  1, 1, 0, 0, 1, 8'd0)};
    tbl[4]  = '{4'b0011, 1'b1, 1'b0, pack(4'd2,  1, 0, 1, 0, 1, 8'd0)};
    tbl[5]  = '{4'b0011, 1'b1, 1'b0, pack(4'd2,  1, 0, 0, 0, 1, 8'd0)};
    tbl[6]  = '{4'b0011, 1'b0, 1'b0, pack(4'd2,  0, 0, 0, 0, 1, 8'd0)};
    tbl[7]  = '{4'b1000, 1'b1, 1'b0, pack(4'd15, 1, 0, 0, 1, 1, 8'd1)};
    tbl[8]  = '{4'b0000, 1'b1, 1'b0, pack(4'd0,  1, 1, 0, 0, 1, 8'd1)};
    tbl[9]  = '{4'b1000, 1'b1, 1'b0, pack(4'd15, 1, 0, 1, 0, 1, 8'd1)};
    tbl[10] = '{4'b1001, 1'b1, 1'b0, pack(4'd14, 1, 0, 1, 0, 1, 8'd1)};
    tbl[11] = '{4'b1000, 1'b1, 1'b0, pack(4'd15, 1, 1, 0, 0, 1, 8'd1)};
    tbl[12] = '{4'b0000, 1'b1, 1'b0, pack(4'd0,  1, 1, 0, 0, 1, 8'd1)};
    tbl[13] = '{4'b0011, 1'b1, 1'b0, pack(4'd2,  1, 0, 0, 1, 1, 8'd2)};
    tbl[14] = '{4'b0000, 1'b1, 1'b1, pack(4'd0,  1, 0, 0, 1, 1, 8'd0)};
    tbl[15] = '{4'b1111, 1'b0, 1'b0, pack(4'd0,  0, 0, 0, 0, 1, 8'd0)};
    tbl[16] = '{4'b0011, 1'b1, 1'b0, pack(4'd2,  1, 0, 0, 1, 0, 8'd1)};
    tbl[17] = '{4'b0001, 1'b1, 1'b0, pack(4'd1,  1, 0, 0, 0, 1, 8'd1)};
    tbl[18] = '{4'b0000, 1'b1, 1'b0, pack(4'd0,  1, 0, 1, 0, 1, 8'd1)};
    tbl[19] = '{4'b1010, 1'b0, 1'b0, pack(4'd0,  0, 0, 0, 0, 1, 8'd1)};
    tbl[20] = '{4'b0110, 1'b0, 1'b0, pack(4'd0,  0, 0, 0, 0, 1, 8'd1)};
    tbl[21] = '{4'b1111, 1'b0, 1'b0, pack(4'd0,  0, 0, 0, 0, 1, 8'd1)};
    tbl[22] = '{4'b0101, 1'b0, 1'b0, pack(4'd0,  0, 0, 0, 0, 1, 8'd1)};
    tbl[23] = '{4'b1100, 1'b0, 1'b0, pack(4'd0,  0, 0, 0, 0, 1, 8'd1)};
    tbl[24] = '{4'b0001, 1'b1, 1'b0, pack(4'd1,  1, 1, 0, 0, 1, 8'd1)};

    // Reset held from time zero, checked before any clock edge.
    #2;
    compare("por_zero", '0);

    do_reset("rst0");
    for (int i = 0; i < NV; i++) begin
      drive_cycle($sformatf("tbl%0d", i), tbl[i].v, tbl[i].g, tbl[i].c, tbl[i].exp);
    end

    // Three consecutive invalid jumps lose sync; next sample resyncs.
    do_reset("rst1");
    drive_cycle("loss_ref",  1'b1, 4'b0000, 1'b0, pack(4'd0, 1, 0, 0, 0, 1, 8'd0));
    drive_cycle("loss_e1",   1'b1, 4'b0011, 1'b0, pack(4'd2, 1, 0, 0, 1, 1, 8'd1));
    drive_cycle("loss_e2",   1'b1, 4'b0000, 1'b0, pack(4'd0, 1, 0, 0, 1, 1, 8'd2));
    drive_cycle("loss_e3",   1'b1, 4'b0011, 1'b0, pack(4'd2, 1, 0, 0, 1, 0, 8'd3));
    drive_cycle("resync",    1'b1, 4'b0001, 1'b0, pack(4'd1, 1, 0, 0, 0, 1, 8'd3));
    drive_cycle("clr_only",  1'b0, 4'b0000, 1'b1, pack(4'd1, 0, 0, 0, 0, 1, 8'd0));
    drive_cycle("clr_keep",  1'b1, 4'b0011, 1'b0, pack(4'd2, 1, 1, 0, 0, 1, 8'd0));

    // Random walk checked against the reference model.
    do_reset("rst2");
    for (int i = 0; i < 400; i++) begin
      logic [WIDTH-1:0] g;
      logic v, c;
      int r;
      r = $urandom_range(0, 9);
      v = (r >= 2);
      if (r <= 5)      g = m_gray ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
      else if (r == 6) g = m_gray;
      else             g = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
      c = ($urandom_range(0, 11) == 0);
      model_cycle($sformatf("rnd%0d", i), v, g, c);
    end

    // Asynchronous reset between edges, then a sample held across release.
    model_cycle("pre_rst_a", 1'b1, 4'b0101, 1'b0);
    model_cycle("pre_rst_b", 1'b1, 4'b0100, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    compare("async_rst_zero", '0);
    model_reset();
    gray_valid = 1'b1;
    gray_in    = 4'b0110;
    clear_err  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back('0);
    @(posedge clk);
    #1;
    score("release_edge");
    model_cycle("first_after_rst", 1'b1, 4'b0110, 1'b0);
    model_cycle("step_after_rst",  1'b1, 4'b0111, 1'b0);

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
